// File: rtl/bin_to_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock, start/busy/done handshake.
// Optional macro LEADING_ZERO_BLANK_EN replaces leading zero digits with the blank code 4'hF.
module bin_to_bcd_converter #(
  parameter int BIN_WIDTH = 14,
  parameter int DIGITS    = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  numInBinary,
  output logic [4*DIGITS-1:0]   bcdOut,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  // Every 3 input bits need at most one decimal digit, so this always holds the full value.
  localparam int SCR_DIGITS = (((BIN_WIDTH + 2) / 3) > DIGITS) ? ((BIN_WIDTH + 2) / 3) : DIGITS;
  localparam int SCR_W      = 4 * SCR_DIGITS;
  localparam int OUT_W      = 4 * DIGITS;
  localparam int CNT_W      = $clog2(BIN_WIDTH + 1);

  function automatic logic [63:0] max_display(input int n);
    logic [63:0] v;
    v = 64'd1;
    for (int i = 0; i < n; i++) v = v * 64'd10;
    return v - 64'd1;
  endfunction

  localparam logic [63:0] MAX_VAL = max_display(DIGITS);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t               state;
  logic [CNT_W-1:0]     count;
  logic [BIN_WIDTH-1:0] bin;
  logic [SCR_W-1:0]     scratch;
  logic [SCR_W-1:0]     adj;
  logic                 ovf_pend;
  logic [OUT_W-1:0]     result;

  always_comb begin
    adj = scratch;
    for (int i = 0; i < SCR_DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // Saturation wins over blanking: all-9s never contains a zero to blank.
  always_comb begin
    result = ovf_pend ? {DIGITS{4'h9}} : scratch[OUT_W-1:0];
`ifdef LEADING_ZERO_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
        if (lead && (result[4*i +: 4] == 4'h0)) result[4*i +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= S_IDLE;
      count    <= '0;
      bin      <= '0;
      scratch  <= '0;
      ovf_pend <= 1'b0;
      bcdOut   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            bin      <= numInBinary;
            scratch  <= '0;
            ovf_pend <= (64'(numInBinary) > MAX_VAL);
            count    <= CNT_W'(BIN_WIDTH);
            busy     <= 1'b1;
            state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          scratch <= SCR_W'({adj, bin[BIN_WIDTH-1]});
          bin     <= {bin[BIN_WIDTH-2:0], 1'b0};
          count   <= count - CNT_W'(1);
          if (count == CNT_W'(1)) state <= S_DONE;
        end
        S_DONE: begin
          bcdOut   <= result;
          overflow <= ovf_pend;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// Directed bench for bin_to_bcd_converter: latency, boundaries, handshake and reset abort.
// Expected values follow LEADING_ZERO_BLANK_EN when the bench is built with it.
module tb_bin_to_bcd_converter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [13:0] numInBinary = '0;
  logic [15:0] bcdOut;
  logic        busy, done, overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int e0 = 0;

  bin_to_bcd_converter #(.BIN_WIDTH(14), .DIGITS(4)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .numInBinary(numInBinary),
    .bcdOut(bcdOut), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Caller is mid-cycle; start is seen by the next edge (E0).
  task automatic launch(input logic [13:0] v);
    numInBinary = v;
    start = 1'b1;
    @(posedge Clk); #1;
    e0 = cyc;
    start = 1'b0;
    numInBinary = 14'd5;
  endtask

  task automatic wait_done(input string tag, output int lat);
    bit seen;
    seen = 1'b0;
    lat = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge Clk); #1;
      if (done) begin
        seen = 1'b1;
        lat = cyc - e0;
      end else if (!busy) begin
        chk({tag, " busy while converting"}, 32'(busy), 32'd1);
      end
    end
    if (!seen) chk({tag, " done timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_result(input string tag, input int lat, input logic [15:0] want,
                              input logic want_ovf);
    chk({tag, " latency"}, 32'(lat), 32'd15);
    chk({tag, " bcd"}, 32'(bcdOut), 32'(want));
    chk({tag, " ovf"}, 32'(overflow), 32'(want_ovf));
    chk({tag, " busy in done cycle"}, 32'(busy), 32'd0);
  endtask

  task automatic run_vec(input string tag, input logic [13:0] v, input logic [15:0] want_plain,
                         input logic [15:0] want_blank, input logic want_ovf);
    int lat;
    logic [15:0] want;
`ifdef LEADING_ZERO_BLANK_EN
    want = want_blank;
`else
    want = want_plain;
`endif
    launch(v);
    wait_done(tag, lat);
    check_result(tag, lat, want, want_ovf);
    @(posedge Clk); #1;
    chk({tag, " done one cycle"}, 32'(done), 32'd0);
    chk({tag, " bcd held"}, 32'(bcdOut), 32'(want));
  endtask

  task automatic watch_no_done(input string tag, input int n);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge Clk); #1;
      if (done) pulses++;
    end
    chk(tag, 32'(pulses), 32'd0);
  endtask

  initial begin
    int lat;
    logic [15:0] w;

    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    chk("rst bcd", 32'(bcdOut), 32'h0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst ovf", 32'(overflow), 32'd0);
    watch_no_done("idle no done", 20);

    run_vec("v1234",  14'd1234,  16'h1234, 16'h1234, 1'b0);
    run_vec("v0",     14'd0,     16'h0000, 16'hFFF0, 1'b0);
    run_vec("v9999",  14'd9999,  16'h9999, 16'h9999, 1'b0);
    run_vec("v10000", 14'd10000, 16'h9999, 16'h9999, 1'b1);
    run_vec("v16383", 14'd16383, 16'h9999, 16'h9999, 1'b1);
    run_vec("v1000",  14'd1000,  16'h1000, 16'h1000, 1'b0);
    run_vec("v7",     14'd7,     16'h0007, 16'hFFF7, 1'b0);
    run_vec("v42",    14'd42,    16'h0042, 16'hFF42, 1'b0);

    // start while busy is ignored
    launch(14'd200);
    repeat (3) @(posedge Clk);
    #1 numInBinary = 14'd77; start = 1'b1;
    @(posedge Clk); #1 start = 1'b0; numInBinary = 14'd5;
    wait_done("hs200", lat);
`ifdef LEADING_ZERO_BLANK_EN
    w = 16'hF200;
`else
    w = 16'h0200;
`endif
    check_result("hs200", lat, w, 1'b0);

    // start in the done cycle is accepted
    launch(14'd77);
    wait_done("hs77", lat);
`ifdef LEADING_ZERO_BLANK_EN
    w = 16'hFF77;
`else
    w = 16'h0077;
`endif
    check_result("hs77", lat, w, 1'b0);
    @(posedge Clk); #1;
    chk("hs77 done one cycle", 32'(done), 32'd0);

    // reset mid-conversion aborts
    launch(14'd4321);
    repeat (5) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk); #1;
    chk("abort bcd", 32'(bcdOut), 32'h0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort ovf", 32'(overflow), 32'd0);
    Reset = 1'b0;
    watch_no_done("abort no done", 25);
    run_vec("post42", 14'd42, 16'h0042, 16'hFF42, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
